exe_mem_pipe: RTL and testbench

Parametrised EXE→MEM pipeline register for the core, the successor of the fixed-width exe/mem latch. It adds a valid bit, a ctrl-driven hold/bubble/flush protocol, and registered misalignment detection for load/store ops. It sits between the execute unit and the memory-access stage and is driven by the ctrl stall vector and the pipeline flush line.

---
 rtl/core_pkg.sv | 38 +++
 rtl/mem_align_chk.sv | 19 +
 rtl/exe_mem_pipe.sv | 134 +++++++++++++
 tb/tb_exe_mem_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: memory op encoding, ctrl constants and op size decode.
package core_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } op_size_e;

  localparam logic STOP          = 1'b1;
  localparam logic NOSTOP        = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // OP_NONE and unused codes report byte size, so they never trap as misaligned.
  function automatic op_size_e op_size(input logic [3:0] op);
    op_size_e sz;
    case (op)
      OP_LH, OP_LHU, OP_SH: sz = SIZE_HALF;
      OP_LW, OP_SW:         sz = SIZE_WORD;
      default:              sz = SIZE_BYTE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Combinational natural-alignment check for a memory op and the low address bits.
module mem_align_chk
  import core_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [1:0] addr_i,
  output logic       misaligned_o
);

  always_comb begin
    misaligned_o = 1'b0;
    case (op_size(op_i))
      SIZE_HALF: misaligned_o = addr_i[0];
      SIZE_WORD: misaligned_o = (addr_i != 2'b00);
      default:   misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_mem_pipe.sv
// EXE->MEM pipeline register with valid bit, hold/bubble/flush control and
// registered misalignment trap. Define EXE_MEM_PERF_EN for stall/bubble counters.
module exe_mem_pipe
  import core_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EXE_IDX = 3,
  parameter int unsigned MEM_IDX = 4
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  reg_wdata_in,
  input  logic [RADDR_W-1:0] reg_waddr_in,
  input  logic               reg_we_in,
  input  logic [DATA_W-1:0]  mem_data_in,
  input  logic [ADDR_W-1:0]  mem_addr_in,
  input  logic               mem_we_in,
  input  logic [3:0]         mem_op_in,
  input  logic [STALL_W-1:0] stall_in,
  input  logic               flush_in,
  output logic               valid_out,
  output logic [DATA_W-1:0]  reg_wdata_out,
  output logic [RADDR_W-1:0] reg_waddr_out,
  output logic               reg_we_out,
  output logic [DATA_W-1:0]  mem_data_out,
  output logic [ADDR_W-1:0]  mem_addr_out,
  output logic               mem_we_out,
  output logic [3:0]         mem_op_out,
  output logic               misalign_out
`ifdef EXE_MEM_PERF_EN
  ,
  output logic [31:0]        stall_cnt_out,
  output logic [31:0]        bubble_cnt_out
`endif
);

  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  reg_wdata;
    logic [RADDR_W-1:0] reg_waddr;
    logic               reg_we;
    logic [DATA_W-1:0]  mem_data;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [3:0]         mem_op;
    logic               misalign;
  } slot_t;

  slot_t slot_q, slot_d, capture;
  logic  align_err, misaligned;
  logic  do_hold, do_bubble;
  logic  unused_stall;

  assign unused_stall = ^stall_in;

  mem_align_chk u_align_chk (
    .op_i         (mem_op_in),
    .addr_i       (mem_addr_in[1:0]),
    .misaligned_o (align_err)
  );

  assign misaligned = valid_in & align_err;

  always_comb begin
    capture           = '0;
    capture.valid     = valid_in;
    capture.reg_wdata = reg_wdata_in;
    capture.reg_waddr = reg_waddr_in;
    capture.reg_we    = (valid_in && !misaligned) ? reg_we_in : WRITE_DISABLE;
    capture.mem_data  = mem_data_in;
    capture.mem_addr  = mem_addr_in;
    capture.mem_we    = (valid_in && !misaligned) ? mem_we_in : WRITE_DISABLE;
    capture.mem_op    = mem_op_in;
    capture.misalign  = misaligned;
  end

  // A MEM stall always holds (the MEM-only case is illegal but treated as hold);
  // only an EXE stall without a MEM stall inserts a bubble.
  always_comb begin
    do_hold   = 1'b0;
    do_bubble = 1'b0;
    slot_d    = capture;
    if (flush_in) begin
      do_bubble = 1'b1;
      slot_d    = '0;
    end else if (stall_in[MEM_IDX] == STOP) begin
      do_hold = 1'b1;
      slot_d  = slot_q;
    end else if (stall_in[EXE_IDX] == STOP) begin
      do_bubble = 1'b1;
      slot_d    = '0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) slot_q <= '0;
    else          slot_q <= slot_d;
  end

  assign valid_out     = slot_q.valid;
  assign reg_wdata_out = slot_q.reg_wdata;
  assign reg_waddr_out = slot_q.reg_waddr;
  assign reg_we_out    = slot_q.reg_we;
  assign mem_data_out  = slot_q.mem_data;
  assign mem_addr_out  = slot_q.mem_addr;
  assign mem_we_out    = slot_q.mem_we;
  assign mem_op_out    = slot_q.mem_op;
  assign misalign_out  = slot_q.misalign;

`ifdef EXE_MEM_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (do_hold && stall_cnt_q != '1)     stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (do_bubble && bubble_cnt_q != '1)  bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_out  = stall_cnt_q;
  assign bubble_cnt_out = bubble_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = do_hold ^ do_bubble;
`endif

endmodule

// File: tb/tb_exe_mem_pipe.sv
// Self-checking bench for exe_mem_pipe: directed scenarios plus randomized traffic
// against a cycle-level reference model of the slot contents.
module tb_exe_mem_pipe;
  import core_pkg::*;

  localparam int DW = 32, AW = 32, RW = 5, SW_ = 6, EXE = 3, MEM = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          valid_in = 1'b0, reg_we_in = 1'b0, mem_we_in = 1'b0, flush_in = 1'b0;
  logic [DW-1:0] reg_wdata_in = '0, mem_data_in = '0;
  logic [RW-1:0] reg_waddr_in = '0;
  logic [AW-1:0] mem_addr_in = '0;
  logic [3:0]    mem_op_in = '0;
  logic [SW_-1:0] stall_in = '0;
  logic          valid_out, reg_we_out, mem_we_out, misalign_out;
  logic [DW-1:0] reg_wdata_out, mem_data_out;
  logic [RW-1:0] reg_waddr_out;
  logic [AW-1:0] mem_addr_out;
  logic [3:0]    mem_op_out;
`ifdef EXE_MEM_PERF_EN
  logic [31:0]   stall_cnt_out, bubble_cnt_out;
`endif

  int checks = 0, failures = 0;

  exe_mem_pipe #(.DATA_W(DW), .ADDR_W(AW), .RADDR_W(RW), .STALL_W(SW_),
                 .EXE_IDX(EXE), .MEM_IDX(MEM)) dut (
    .clk_in(clk), .reset_in(rst), .valid_in(valid_in),
    .reg_wdata_in(reg_wdata_in), .reg_waddr_in(reg_waddr_in), .reg_we_in(reg_we_in),
    .mem_data_in(mem_data_in), .mem_addr_in(mem_addr_in), .mem_we_in(mem_we_in),
    .mem_op_in(mem_op_in), .stall_in(stall_in), .flush_in(flush_in),
    .valid_out(valid_out), .reg_wdata_out(reg_wdata_out), .reg_waddr_out(reg_waddr_out),
    .reg_we_out(reg_we_out), .mem_data_out(mem_data_out), .mem_addr_out(mem_addr_out),
    .mem_we_out(mem_we_out), .mem_op_out(mem_op_out), .misalign_out(misalign_out)
`ifdef EXE_MEM_PERF_EN
    , .stall_cnt_out(stall_cnt_out), .bubble_cnt_out(bubble_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) assert (!(stall_in[MEM] && !stall_in[EXE])) else $error("illegal MEM-only stall driven");

  // Reference model: expected MEM slot contents.
  logic          e_valid, e_rwe, e_mwe, e_mis;
  logic [DW-1:0] e_wdata, e_mdata;
  logic [RW-1:0] e_waddr;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_op;
  longint unsigned e_stall_cnt, e_bubble_cnt;

  task automatic model_clear();
    {e_valid, e_rwe, e_mwe, e_mis} = '0;
    e_wdata = '0; e_mdata = '0; e_waddr = '0; e_addr = '0; e_op = 4'd0;
  endtask

  task automatic model_reset();
    model_clear();
    e_stall_cnt = 0; e_bubble_cnt = 0;
  endtask

  task automatic model_bubble();
    model_clear();
    if (e_bubble_cnt < 64'hFFFF_FFFF) e_bubble_cnt++;
  endtask

  task automatic model_hold();
    if (e_stall_cnt < 64'hFFFF_FFFF) e_stall_cnt++;
  endtask

  task automatic model_capture();
    int unsigned a;
    bit is_half, is_word, mis;
    a = mem_addr_in;
    is_half = (mem_op_in == 4'd2) || (mem_op_in == 4'd5) || (mem_op_in == 4'd7);
    is_word = (mem_op_in == 4'd3) || (mem_op_in == 4'd8);
    mis = valid_in && ((is_half && (a % 2 != 0)) || (is_word && (a % 4 != 0)));
    e_valid = valid_in; e_wdata = reg_wdata_in; e_waddr = reg_waddr_in;
    e_mdata = mem_data_in; e_addr = mem_addr_in; e_op = mem_op_in; e_mis = mis;
    e_rwe = valid_in && !mis && reg_we_in;
    e_mwe = valid_in && !mis && mem_we_in;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge.
  task automatic tick();
    bit ex, me;
    ex = stall_in[EXE]; me = stall_in[MEM];
    if (flush_in)        model_bubble();
    else if (ex && me)   model_hold();
    else if (ex)         model_bubble();
    else if (me)         model_hold();
    else                 model_capture();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [AW-1:0] addr,
                       input bit rwe, input bit mwe, input logic [DW-1:0] data,
                       input logic [SW_-1:0] st, input bit fl);
    valid_in = v; mem_op_in = op; mem_addr_in = addr; reg_we_in = rwe; mem_we_in = mwe;
    reg_wdata_in = data; mem_data_in = ~data; reg_waddr_in = data[RW-1:0];
    stall_in = st; flush_in = fl;
  endtask

  task automatic test_reset();
    drive(1, OP_LW, 32'h104, 1, 1, 32'hDEAD_BEEF, '0, 0);
    tick();
    rst = 1'b1; model_reset(); #2;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", valid_out); end
    checks++; if (mem_op_out !== 4'd0) begin failures++; $display("FAIL reset_op got=%0h exp=0", mem_op_out); end
    checks++; if ({reg_wdata_out, mem_data_out, mem_addr_out, reg_waddr_out, reg_we_out, mem_we_out, misalign_out} !== '0) begin
      failures++; $display("FAIL reset_fields got_addr=%0h got_wdata=%0h exp=0", mem_addr_out, reg_wdata_out); end
`ifdef EXE_MEM_PERF_EN
    checks++; if ({stall_cnt_out, bubble_cnt_out} !== 64'd0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0", stall_cnt_out, bubble_cnt_out); end
`endif
    @(negedge clk); rst = 1'b0; @(posedge clk); #1;
  endtask

  task automatic test_flow();
    drive(1, OP_LW, 32'h100, 1, 0, 32'h1234_5678, '0, 0);
    tick();
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL flow_valid got=%0h exp=1", valid_out); end
    checks++; if (mem_op_out !== 4'd3) begin failures++; $display("FAIL flow_op got=%0h exp=3", mem_op_out); end
    checks++; if (mem_addr_out !== 32'h100) begin failures++; $display("FAIL flow_addr got=%0h exp=100", mem_addr_out); end
    checks++; if (misalign_out !== 1'b0 || reg_we_out !== 1'b1) begin failures++; $display("FAIL flow_mis_we got=%0h/%0h exp=0/1", misalign_out, reg_we_out); end
    checks++; if (reg_wdata_out !== 32'h1234_5678) begin failures++; $display("FAIL flow_wdata got=%0h exp=12345678", reg_wdata_out); end
  endtask

  task automatic test_misalign();
    drive(1, OP_SW, 32'h102, 0, 1, 32'hA5A5_0001, '0, 0);
    tick();
    checks++; if (misalign_out !== 1'b1) begin failures++; $display("FAIL sw_mis got=%0h exp=1", misalign_out); end
    checks++; if (mem_we_out !== 1'b0) begin failures++; $display("FAIL sw_mwe got=%0h exp=0", mem_we_out); end
    checks++; if (mem_addr_out !== 32'h102 || mem_op_out !== 4'd8) begin failures++; $display("FAIL sw_addr_op got=%0h/%0h exp=102/8", mem_addr_out, mem_op_out); end
    drive(1, OP_SH, 32'h102, 0, 1, 32'hA5A5_0002, '0, 0);
    tick();
    checks++; if (misalign_out !== 1'b0 || mem_we_out !== 1'b1) begin failures++; $display("FAIL sh_ok got=%0h/%0h exp=0/1", misalign_out, mem_we_out); end
    drive(1, OP_LHU, 32'h101, 1, 0, 32'h3, '0, 0);
    tick();
    checks++; if (misalign_out !== 1'b1 || reg_we_out !== 1'b0) begin failures++; $display("FAIL lhu_mis got=%0h/%0h exp=1/0", misalign_out, reg_we_out); end
    drive(1, OP_LB, 32'h103, 1, 0, 32'h4, '0, 0);
    tick();
    checks++; if (misalign_out !== 1'b0 || reg_we_out !== 1'b1) begin failures++; $display("FAIL lb_ok got=%0h/%0h exp=0/1", misalign_out, reg_we_out); end
    drive(0, OP_SW, 32'h103, 1, 1, 32'h5, '0, 0);
    tick();
    checks++; if ({valid_out, misalign_out, reg_we_out, mem_we_out} !== 4'b0000) begin
      failures++; $display("FAIL invalid_gate got=%b exp=0000", {valid_out, misalign_out, reg_we_out, mem_we_out}); end
  endtask

  task automatic test_double_stall();
`ifdef EXE_MEM_PERF_EN
    logic [31:0] sc0;
`endif
    drive(1, OP_SB, 32'h7, 0, 1, 32'hCAFE_0007, '0, 0);
    tick();
`ifdef EXE_MEM_PERF_EN
    sc0 = stall_cnt_out;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_LW, 32'h500 + i, 1, 1, 32'h9999_0000 + i, 6'b011000, 0);
      tick();
      checks++; if ({valid_out, mem_op_out, mem_addr_out, mem_we_out, reg_wdata_out} !== {1'b1, 4'd6, 32'h7, 1'b1, 32'hCAFE_0007}) begin
        failures++; $display("FAIL hold_frozen cyc=%0d got op=%0h addr=%0h data=%0h exp op=6 addr=7 data=cafe0007", i, mem_op_out, mem_addr_out, reg_wdata_out); end
    end
`ifdef EXE_MEM_PERF_EN
    checks++; if (stall_cnt_out - sc0 !== 32'd3) begin failures++; $display("FAIL hold_cnt got=%0d exp=3", stall_cnt_out - sc0); end
`endif
    drive(1, OP_LW, 32'h200, 1, 0, 32'h2222_0000, '0, 0);
    tick();
    checks++; if (mem_addr_out !== 32'h200 || mem_op_out !== 4'd3) begin failures++; $display("FAIL hold_release got=%0h/%0h exp=200/3", mem_addr_out, mem_op_out); end
    drive(1, OP_LH, 32'h301, 1, 0, 32'h1, '0, 0);
    tick();
    drive(1, OP_LW, 32'h400, 1, 0, 32'h2, 6'b011000, 0);
    tick(); tick();
    checks++; if (misalign_out !== 1'b1 || mem_addr_out !== 32'h301) begin failures++; $display("FAIL hold_mis got=%0h/%0h exp=1/301", misalign_out, mem_addr_out); end
  endtask

  task automatic test_exe_stall();
    drive(1, OP_SW, 32'h40, 1, 1, 32'h4444_4444, 6'b001000, 0);
    tick();
    checks++; if ({valid_out, reg_we_out, mem_we_out, mem_op_out, misalign_out, mem_addr_out, reg_wdata_out} !== '0) begin
      failures++; $display("FAIL exe_bubble got v=%0h rwe=%0h mwe=%0h op=%0h addr=%0h exp=0", valid_out, reg_we_out, mem_we_out, mem_op_out, mem_addr_out); end
  endtask

  task automatic test_flush_over_hold();
`ifdef EXE_MEM_PERF_EN
    logic [31:0] bc0;
`endif
    drive(1, OP_LW, 32'h80, 1, 0, 32'h8, '0, 0);
    tick();
`ifdef EXE_MEM_PERF_EN
    bc0 = bubble_cnt_out;
`endif
    drive(1, OP_LW, 32'h84, 1, 0, 32'h9, 6'b011000, 1);
    tick();
    checks++; if ({valid_out, reg_we_out, mem_op_out, mem_addr_out} !== '0) begin
      failures++; $display("FAIL flush_hold got v=%0h op=%0h addr=%0h exp=0", valid_out, mem_op_out, mem_addr_out); end
`ifdef EXE_MEM_PERF_EN
    checks++; if (bubble_cnt_out - bc0 !== 32'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", bubble_cnt_out - bc0); end
`endif
  endtask

  task automatic test_async_reset();
    drive(1, OP_SW, 32'h600, 0, 1, 32'h6, '0, 0);
    tick();
    drive(1, OP_SW, 32'h604, 0, 1, 32'h7, 6'b011000, 0);
    tick();
    #2 rst = 1'b1; model_reset();
    #1;
    checks++; if ({valid_out, mem_we_out, mem_op_out, mem_addr_out, mem_data_out} !== '0) begin
      failures++; $display("FAIL async_rst got v=%0h op=%0h addr=%0h exp=0", valid_out, mem_op_out, mem_addr_out); end
    @(negedge clk); rst = 1'b0;
    drive(1, OP_LW, 32'h300, 1, 0, 32'h3, '0, 0);
    #1 tick();
    checks++; if (valid_out !== 1'b1 || mem_addr_out !== 32'h300) begin failures++; $display("FAIL async_resume got=%0h/%0h exp=1/300", valid_out, mem_addr_out); end
  endtask

  task automatic test_random();
    logic [SW_-1:0] st;
    int unsigned r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 3);
      st = SW_'($urandom) & ~(SW_'(1) << EXE) & ~(SW_'(1) << MEM);
      if (r == 2) st[EXE] = 1'b1;
      if (r == 3) begin st[EXE] = 1'b1; st[MEM] = 1'b1; end
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 8)), AW'($urandom),
            1'($urandom), 1'($urandom), DW'($urandom), st, $urandom_range(0, 9) == 0);
      tick();
      checks++; if (valid_out !== e_valid || misalign_out !== e_mis) begin
        failures++; $display("FAIL rnd_valid_mis n=%0d got=%b%b exp=%b%b", n, valid_out, misalign_out, e_valid, e_mis); end
      checks++; if (reg_we_out !== e_rwe || mem_we_out !== e_mwe) begin
        failures++; $display("FAIL rnd_we n=%0d got=%b%b exp=%b%b", n, reg_we_out, mem_we_out, e_rwe, e_mwe); end
      checks++; if (mem_op_out !== e_op || mem_addr_out !== e_addr) begin
        failures++; $display("FAIL rnd_op_addr n=%0d got=%0h/%0h exp=%0h/%0h", n, mem_op_out, mem_addr_out, e_op, e_addr); end
      checks++; if (reg_wdata_out !== e_wdata || mem_data_out !== e_mdata || reg_waddr_out !== e_waddr) begin
        failures++; $display("FAIL rnd_data n=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", n, reg_wdata_out, mem_data_out, reg_waddr_out, e_wdata, e_mdata, e_waddr); end
`ifdef EXE_MEM_PERF_EN
      checks++; if (stall_cnt_out !== e_stall_cnt[31:0] || bubble_cnt_out !== e_bubble_cnt[31:0]) begin
        failures++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cnt_out, bubble_cnt_out, e_stall_cnt, e_bubble_cnt); end
`endif
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_flow();
    test_misalign();
    test_double_stall();
    test_exe_stall();
    test_flush_over_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
